// File: rtl/tile_fetch_ctrl_pkg.sv
// Shared types for the tile fetch controller: shapes, datatypes, AXI descriptors, FSM states.
// Sizing constants and helpers for per-matrix element counts and element widths.
package tile_fetch_ctrl_pkg;

  localparam int AXI_DATA_MAX = 256;
  localparam int ADDR_W       = 32;
  localparam int BURST_W      = 16;

  typedef enum logic [1:0] {
    M32K16N8   = 2'b00,
    M16K16N16  = 2'b01,
    M8K16N32   = 2'b10,
    SHAPE_RSVD = 2'b11
  } shape_t;

  typedef enum logic [1:0] {FP32 = 2'b00, FP16 = 2'b01, INT8 = 2'b10, INT4 = 2'b11} type_t;

  typedef enum logic [1:0] {MAT_A = 2'b00, MAT_B = 2'b01, MAT_C = 2'b10, MAT_D = 2'b11} mat_t;

  typedef struct packed {
    shape_t compute_shape;
    type_t  data_type;
  } compute_type_t;

  typedef struct packed {
    logic [ADDR_W-1:0] a_base;
    logic [ADDR_W-1:0] b_base;
    logic [ADDR_W-1:0] c_base;
    logic [ADDR_W-1:0] d_base;
  } baseaddr_t;

  typedef struct packed {
    logic                    arready;
    logic                    rvalid;
    logic [AXI_DATA_MAX-1:0] data;
    logic                    finish;
  } AXI_in_t;

  typedef struct packed {
    logic               request_valid;
    logic [ADDR_W-1:0]  BASE;
    logic [2:0]         sel;
    logic               issend;
    logic [BURST_W-1:0] burst_num;
    logic [2:0]         burst_size;
  } AXI_out_t;

  typedef struct packed {
    logic [31:0] systolic_time;
    logic [31:0] waitwrite_time;
    logic [31:0] writeback_time;
  } SYSTOLIC_pkg_t;

  typedef enum logic [3:0] {
    IDLE, REQ_C, RD_C, REQ_A, RD_A, REQ_B, RD_B, COMPUTE, REQ_D, WR_D, DONE
  } fetch_state_t;

  // Element sizes in half-bytes so INT4 stays integral; C/D are always 32-bit accumulators.
  localparam int HB_FP32 = 8;
  localparam int HB_FP16 = 4;
  localparam int HB_INT8 = 2;
  localparam int HB_INT4 = 1;
  localparam int HB_ACC  = 8;

  localparam int ELEM_AB_LARGE = 512;
  localparam int ELEM_AB_MID   = 256;
  localparam int ELEM_AB_SMALL = 128;
  localparam int ELEM_CD       = 256;

  function automatic int elem_count(shape_t shape, mat_t mat);
    int n;
    n = 0;
    case (mat)
      MAT_A: case (shape)
        M32K16N8:  n = ELEM_AB_LARGE;
        M16K16N16: n = ELEM_AB_MID;
        M8K16N32:  n = ELEM_AB_SMALL;
        default:   n = 0;
      endcase
      MAT_B: case (shape)
        M32K16N8:  n = ELEM_AB_SMALL;
        M16K16N16: n = ELEM_AB_MID;
        M8K16N32:  n = ELEM_AB_LARGE;
        default:   n = 0;
      endcase
      default: n = ELEM_CD;
    endcase
    return n;
  endfunction

  function automatic int half_bytes(type_t dtype, mat_t mat);
    int hb;
    if (mat == MAT_C || mat == MAT_D) hb = HB_ACC;
    else case (dtype)
      FP32:    hb = HB_FP32;
      FP16:    hb = HB_FP16;
      INT8:    hb = HB_INT8;
      default: hb = HB_INT4;
    endcase
    return hb;
  endfunction

endpackage

// File: rtl/tile_fetch_ctrl_beat_calc.sv
// Combinational burst length for one matrix: (shape, datatype, mat) -> beats-1.
module tile_beat_calc
  import tile_fetch_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 256
) (
  input  shape_t             shape,
  input  type_t              dtype,
  input  mat_t               mat,
  output logic [BURST_W-1:0] burst_num
);

  localparam logic [31:0] DW = 32'(DATA_WIDTH);

  logic [31:0] bits;
  logic [31:0] beats;

  always_comb begin
    // half-bytes * 4 = bits
    bits      = 32'(elem_count(shape, mat) * half_bytes(dtype, mat) * 4);
    beats     = bits / DW;
    burst_num = '0;
    if (beats != 32'd0) burst_num = BURST_W'(beats - 32'd1);
  end

endmodule

// File: rtl/tile_fetch_ctrl.sv
// Tile fetch sequencer: reads C, A, B over AXI, triggers compute, writes D back.
// Optional per-tile cycle counters on the perf port when TILE_FETCH_PERF_EN is defined.
module tile_fetch_ctrl
  import tile_fetch_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  compute_type_t         cfg,
  input  baseaddr_t             base,
  input  AXI_in_t               axi_in,
  input  logic                  compute_done,
  output AXI_out_t              axi_out,
  output logic                  load_valid,
  output mat_t                  load_mat,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  compute_start,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef TILE_FETCH_PERF_EN
  ,
  output SYSTOLIC_pkg_t         perf
`endif
);

  localparam logic [2:0] BURST_SIZE = 3'($clog2(DATA_WIDTH / 8));

  fetch_state_t       state, state_nx;
  compute_type_t      cfg_q;
  baseaddr_t          base_q;
  logic [BURST_W-1:0] beat_cnt, cnt_incl, burst_num, beats;
  mat_t               cur_mat;
  logic               is_req, is_rd, accept, err_nx;

  tile_beat_calc #(.DATA_WIDTH(DATA_WIDTH)) u_beat_calc (
    .shape     (cfg_q.compute_shape),
    .dtype     (cfg_q.data_type),
    .mat       (cur_mat),
    .burst_num (burst_num)
  );

  assign is_req   = state inside {REQ_C, REQ_A, REQ_B, REQ_D};
  assign is_rd    = state inside {RD_C, RD_A, RD_B};
  assign beats    = burst_num + 1'b1;
  assign cnt_incl = beat_cnt + {{(BURST_W-1){1'b0}}, axi_in.rvalid};
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_comb begin
    case (state)
      REQ_A, RD_A: cur_mat = MAT_A;
      REQ_B, RD_B: cur_mat = MAT_B;
      REQ_D, WR_D: cur_mat = MAT_D;
      default:     cur_mat = MAT_C;
    endcase
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (cfg.compute_shape == SHAPE_RSVD) err_nx = 1'b1;
        else begin
          state_nx = REQ_C;
          accept   = 1'b1;
        end
      end
      REQ_C:   if (axi_in.arready) state_nx = RD_C;
      RD_C:    if (axi_in.finish)  state_nx = REQ_A;
      REQ_A:   if (axi_in.arready) state_nx = RD_A;
      RD_A:    if (axi_in.finish)  state_nx = REQ_B;
      REQ_B:   if (axi_in.arready) state_nx = RD_B;
      RD_B:    if (axi_in.finish)  state_nx = COMPUTE;
      COMPUTE: if (compute_done)   state_nx = REQ_D;
      REQ_D:   if (axi_in.arready) state_nx = WR_D;
      WR_D:    if (axi_in.finish)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // a short or long read still advances; only the error is flagged
    if (is_rd && axi_in.finish && (cnt_incl != beats)) err_nx = 1'b1;
  end

  always_comb begin
    axi_out    = '0;
    load_valid = 1'b0;
    load_mat   = MAT_A;
    load_data  = '0;
    if (is_req) begin
      axi_out.request_valid = 1'b1;
      axi_out.issend        = (cur_mat == MAT_D);
      axi_out.burst_num     = burst_num;
      axi_out.burst_size    = BURST_SIZE;
      case (cur_mat)
        MAT_A:   begin axi_out.BASE = base_q.a_base; axi_out.sel = 3'b100; end
        MAT_B:   begin axi_out.BASE = base_q.b_base; axi_out.sel = 3'b010; end
        MAT_C:   begin axi_out.BASE = base_q.c_base; axi_out.sel = 3'b001; end
        default: begin axi_out.BASE = base_q.d_base; axi_out.sel = 3'b000; end
      endcase
    end
    if (is_rd) begin
      load_valid = axi_in.rvalid;
      load_mat   = cur_mat;
      load_data  = axi_in.data[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cfg_q         <= '0;
      base_q        <= '0;
      beat_cnt      <= '0;
      err           <= 1'b0;
      compute_start <= 1'b0;
    end else begin
      state         <= state_nx;
      err           <= err_nx;
      compute_start <= (state_nx == COMPUTE) && (state != COMPUTE);
      if (accept) begin
        cfg_q  <= cfg;
        base_q <= base;
      end
      if (is_rd) begin
        if (axi_in.finish)      beat_cnt <= '0;
        else if (axi_in.rvalid) beat_cnt <= beat_cnt + 1'b1;
      end else begin
        beat_cnt <= '0;
      end
    end
  end

`ifdef TILE_FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf <= '0;
    else if (accept) perf <= '0;
    else begin
      case (state)
        COMPUTE: perf.systolic_time  <= perf.systolic_time + 32'd1;
        REQ_D:   perf.waitwrite_time <= perf.waitwrite_time + 32'd1;
        WR_D:    perf.writeback_time <= perf.writeback_time + 32'd1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_tile_fetch_ctrl.sv
// Randomized and directed bench for tile_fetch_ctrl against a transaction-level model.
module tb_tile_fetch_ctrl;
  import tile_fetch_ctrl_pkg::*;

  localparam int DW        = 256;
  localparam int EXP_BSIZE = $clog2(DW / 8);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  compute_type_t cfg;
  baseaddr_t     base;
  AXI_in_t       ain;
  logic          compute_done;
  AXI_out_t      axi_out;
  logic          load_valid;
  mat_t          load_mat;
  logic [DW-1:0] load_data;
  logic          compute_start, busy, done, err;
`ifdef TILE_FETCH_PERF_EN
  SYSTOLIC_pkg_t perf;
`endif

  always #5 clk = ~clk;

  tile_fetch_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg(cfg), .base(base), .axi_in(ain),
    .compute_done(compute_done), .axi_out(axi_out), .load_valid(load_valid),
    .load_mat(load_mat), .load_data(load_data), .compute_start(compute_start),
    .busy(busy), .done(done), .err(err)
`ifdef TILE_FETCH_PERF_EN
    , .perf(perf)
`endif
  );

  int checks = 0, failures = 0;
  int err_seen = 0, done_seen = 0;

  // expectations for the current cycle, set by the driver from the model
  bit            exp_busy, exp_req, exp_lv, exp_cs, exp_done, exp_rst;
  logic [31:0]   exp_base;
  logic [2:0]    exp_sel;
  bit            exp_issend;
  int            exp_burst;
  mat_t          exp_lmat;
  logic [DW-1:0] exp_ldata;

  shape_t      cur_shape;
  type_t       cur_type;
  baseaddr_t   cur_base;
  int          t_dly[4];
  int          t_adj[3];
  bit          t_gaps, t_stray, t_abort;
  logic [15:0] seen_burst[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Spec arithmetic: bytes = elements * bytes/elem (INT4 = half byte), beats = bytes*8/DW.
  function automatic int model_burst(shape_t s, type_t t, mat_t m);
    int elems, hb;
    int idx;
    idx = (s == M32K16N8) ? 0 : (s == M16K16N16) ? 1 : 2;
    if (m == MAT_A)      elems = (idx == 0) ? 512 : (idx == 1) ? 256 : 128;
    else if (m == MAT_B) elems = (idx == 0) ? 128 : (idx == 1) ? 256 : 512;
    else                 elems = 256;
    if (m == MAT_C || m == MAT_D) hb = 8;
    else hb = (t == FP32) ? 8 : (t == FP16) ? 4 : (t == INT8) ? 2 : 1;
    return (elems * hb / 2) * 8 / DW - 1;
  endfunction

  function automatic logic [31:0] base_of(mat_t m);
    case (m)
      MAT_A:   return cur_base.a_base;
      MAT_B:   return cur_base.b_base;
      MAT_C:   return cur_base.c_base;
      default: return cur_base.d_base;
    endcase
  endfunction

  always @(negedge clk) begin
    if (err === 1'b1) err_seen++;
    if (done === 1'b1) done_seen++;
    chk("busy", 64'(busy), 64'(exp_busy));
    chk("request_valid", 64'(axi_out.request_valid), 64'(exp_req));
    if (exp_rst) chk("axi_out_reset", 64'(axi_out), 64'd0);
    if (exp_req) begin
      chk("base", 64'(axi_out.BASE), 64'(exp_base));
      chk("sel", 64'(axi_out.sel), 64'(exp_sel));
      chk("issend", 64'(axi_out.issend), 64'(exp_issend));
      chk("burst_num", 64'(axi_out.burst_num), 64'(exp_burst));
      chk("burst_size", 64'(axi_out.burst_size), 64'(EXP_BSIZE));
    end
    chk("load_valid", 64'(load_valid), 64'(exp_lv));
    if (exp_lv) begin
      chk("load_mat", 64'(load_mat), 64'(exp_lmat));
      checks++;
      if (load_data !== exp_ldata) begin
        failures++;
        $display("FAIL load_data actual=%0h required=%0h", load_data, exp_ldata);
      end
    end
    chk("compute_start", 64'(compute_start), 64'(exp_cs));
    chk("done", 64'(done), 64'(exp_done));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input bit b);
    exp_busy = b; exp_req = 1'b0; exp_lv = 1'b0; exp_cs = 1'b0;
    exp_done = 1'b0; exp_rst = 1'b0;
  endtask

  task automatic rand_cfg_base();
    cfg.compute_shape = shape_t'($urandom_range(0, 2));
    cfg.data_type     = type_t'($urandom_range(0, 3));
    base = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic do_req(input mat_t m, input int dly);
    quiet(1'b1);
    exp_req    = 1'b1;
    exp_base   = base_of(m);
    exp_sel    = (m == MAT_A) ? 3'b100 : (m == MAT_B) ? 3'b010 : (m == MAT_C) ? 3'b001 : 3'b000;
    exp_issend = (m == MAT_D);
    exp_burst  = model_burst(cur_shape, cur_type, m);
    for (int i = 0; i < dly; i++) begin
      ain.rvalid   = 1'($urandom_range(0, 1));
      compute_done = 1'($urandom_range(0, 1));
      tick();
    end
    ain.rvalid   = 1'b0;
    compute_done = 1'b0;
    ain.arready  = 1'b1;
    seen_burst.push_back(axi_out.burst_num);
    tick();
    ain.arready = 1'b0;
  endtask

  task automatic do_rd(input mat_t m, input int n, input bit fin_last, input bit stray);
    quiet(1'b1);
    for (int i = 0; i < n; i++) begin
      if (t_gaps && $urandom_range(0, 2) == 0) begin
        ain.rvalid = 1'b0; exp_lv = 1'b0;
        tick();
      end
      ain.rvalid = 1'b1;
      ain.data   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ain.finish = fin_last && (i == n - 1);
      exp_lv = 1'b1; exp_lmat = m; exp_ldata = ain.data;
      if (stray && i == 0) begin
        start = 1'b1;
        rand_cfg_base();
      end
      tick();
      start = 1'b0;
    end
    if (!fin_last) begin
      ain.rvalid = 1'b0; ain.finish = 1'b1; exp_lv = 1'b0;
      tick();
    end
    ain.rvalid = 1'b0; ain.finish = 1'b0; exp_lv = 1'b0;
  endtask

  task automatic run_tile(input shape_t s, input type_t t);
    int   e0, d0, exp_err, n, w;
    mat_t mats[3];
    mats = '{MAT_C, MAT_A, MAT_B};
    e0 = err_seen; d0 = done_seen; exp_err = 0;
    cur_shape = s; cur_type = t;
    cur_base  = {$urandom, $urandom, $urandom, $urandom};
    quiet(1'b0);
    start = 1'b1; cfg.compute_shape = s; cfg.data_type = t; base = cur_base;
    tick();
    start = 1'b0;
    rand_cfg_base();
    for (int k = 0; k < 3; k++) begin
      do_req(mats[k], t_dly[k]);
      if (t_abort && k == 1) begin
        quiet(1'b1);
        for (int i = 0; i < 3; i++) begin
          ain.rvalid = 1'b1; ain.data = {8{$urandom}};
          exp_lv = 1'b1; exp_lmat = MAT_A; exp_ldata = ain.data;
          tick();
        end
        rst = 1'b1;
        quiet(1'b0); exp_rst = 1'b1;
        tick(); tick();
        rst = 1'b0; ain.rvalid = 1'b0; exp_rst = 1'b0;
        tick();
        chk("abort_err_pulses", 64'(err_seen - e0), 64'd0);
        return;
      end
      n = model_burst(s, t, mats[k]) + 1 + t_adj[k];
      if (t_adj[k] != 0) exp_err++;
      do_rd(mats[k], n, 1'($urandom_range(0, 1)), t_stray && k == 0);
    end
    // COMPUTE: compute_start only on the first cycle; stray rvalid must not load
    quiet(1'b1); exp_cs = 1'b1;
    w = $urandom_range(0, 3);
    ain.rvalid = 1'b1;
    compute_done = (w == 0);
    tick();
    exp_cs = 1'b0;
    for (int i = 0; i < w; i++) begin
      compute_done = (i == w - 1);
      tick();
    end
    compute_done = 1'b0; ain.rvalid = 1'b0;
    do_req(MAT_D, t_dly[3]);
    quiet(1'b1);
    w = $urandom_range(0, 3);
    for (int i = 0; i < w; i++) begin
      ain.rvalid = 1'($urandom_range(0, 1));
      tick();
    end
    ain.rvalid = 1'b0; ain.finish = 1'b1;
    tick();
    ain.finish = 1'b0;
    exp_done = 1'b1;
    tick();
    quiet(1'b0);
    tick();
    chk("err_pulses", 64'(err_seen - e0), 64'(exp_err));
    chk("done_pulses", 64'(done_seen - d0), 64'd1);
  endtask

  task automatic clear_knobs();
    t_dly = '{0, 0, 0, 0};
    t_adj = '{0, 0, 0};
    t_gaps = 1'b0; t_stray = 1'b0; t_abort = 1'b0;
    seen_burst.delete();
  endtask

  initial begin
    int e0;
    rst = 1'b1; start = 1'b0; cfg = '0; base = '0; ain = '0; compute_done = 1'b0;
    quiet(1'b0); exp_rst = 1'b1;
    clear_knobs();
    tick(); tick();
    rst = 1'b0; exp_rst = 1'b0;
    tick();

    // zero-latency arready, M16K16N16 FP16
    run_tile(M16K16N16, FP16);
    chk("lit_c_burst", 64'(seen_burst[0]), 64'd31);
    chk("lit_a_burst", 64'(seen_burst[1]), 64'd15);
    chk("lit_b_burst", 64'(seen_burst[2]), 64'd15);
    chk("lit_d_burst", 64'(seen_burst[3]), 64'd31);

    clear_knobs();
    run_tile(M32K16N8, FP32);
    chk("lit_a_fp32", 64'(seen_burst[1]), 64'd63);
    clear_knobs();
    run_tile(M8K16N32, INT4);
    chk("lit_b_int4", 64'(seen_burst[2]), 64'd7);

    // arready held low for 10 cycles in REQ_A
    clear_knobs(); t_dly[1] = 10;
    run_tile(M16K16N16, INT8);

    // 14 of 16 B beats
    clear_knobs(); t_adj[2] = -2;
    run_tile(M16K16N16, FP16);

    // reserved shape is rejected
    e0 = err_seen;
    quiet(1'b0);
    start = 1'b1; cfg.compute_shape = SHAPE_RSVD; cfg.data_type = FP32;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("reject_err", 64'(err_seen - e0), 64'd1);

    // second start during RD_C is ignored
    clear_knobs(); t_stray = 1'b1; t_gaps = 1'b1;
    run_tile(M8K16N32, FP16);

    // reset in RD_A, then a full replay
    clear_knobs(); t_abort = 1'b1;
    run_tile(M32K16N8, INT8);
    clear_knobs();
    run_tile(M32K16N8, INT8);
    chk("replay_c_burst", 64'(seen_burst[0]), 64'd31);

    for (int r = 0; r < 10; r++) begin
      clear_knobs();
      for (int k = 0; k < 4; k++) t_dly[k] = $urandom_range(0, 3);
      for (int k = 0; k < 3; k++)
        t_adj[k] = ($urandom_range(0, 4) == 0) ? (($urandom_range(0, 1) == 1) ? 1 : -1) : 0;
      t_gaps  = 1'($urandom_range(0, 1));
      t_stray = 1'($urandom_range(0, 1));
      run_tile(shape_t'($urandom_range(0, 2)), type_t'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_fetch_ctrl.md
TILE_FETCH_CTRL -- requirements
Module: tile_fetch_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 256: AXI data beat width in bits; burst_size output = clog2(DATA_WIDTH/8), so 5 at default.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse that launches one tile; sampled only in IDLE.
REQ-005 cfg  input  compute_type_t  shape and datatype; captured on an accepted start.
REQ-006 base  input  baseaddr_t  A/B/C/D base byte addresses; captured on an accepted start.
REQ-007 axi_in  input  AXI_in_t  arready, rvalid, data, finish from the AXI master.
REQ-008 compute_done  input  1  pulse from the systolic array: accumulation complete.
REQ-009 axi_out  output  AXI_out_t  request descriptor to the AXI master.
REQ-010 load_valid  output  1  qualifies load_mat and load_data.
REQ-011 load_mat  output  mat_t  destination buffer for load_data.
REQ-012 load_data  output  DATA_WIDTH  forwarded read beat.
REQ-013 compute_start  output  1  one-cycle pulse to the systolic array.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 done  output  1  one-cycle pulse when the tile is finished.
REQ-016 err  output  1  one-cycle pulse on a rejected config or a beat-count mismatch.

Function
REQ-017 States SHALL be IDLE, REQ_C, RD_C, REQ_A, RD_A, REQ_B, RD_B, COMPUTE, REQ_D, WR_D, DONE, visited in that order.
REQ-018 IDLE->REQ_C SHALL occur on start when cfg.compute_shape is M32K16N8, M16K16N16 or M8K16N32.
REQ-019 When start arrives with compute_shape 2'b11, the block SHALL pulse err and stay in IDLE.
REQ-020 Bytes per element SHALL be FP32=4, FP16=2, INT8=1 and INT4=0.5 for A and B; C and D SHALL always use 4 bytes per element.
REQ-021 Element counts by shape (M32K16N8 / M16K16N16 / M8K16N32) SHALL be: A = 512 / 256 / 128; B = 128 / 256 / 512; C and D = 256 for every shape.
REQ-022 beats = bytes*8/DATA_WIDTH, and burst_num SHALL equal beats-1.
REQ-023 In each REQ_x state, axi_out SHALL carry:
  - request_valid=1 and BASE = that matrix's base;
  - sel = 100 (A), 010 (B), 001 (C) or 000 (D);
  - issend = 1 for D, 0 otherwise.
REQ-024 request_valid SHALL hold, with every field stable, until a cycle with arready=1, then move to the matching RD_x/WR_D state with request_valid=0.
REQ-025 In RD_x, each rvalid cycle SHALL drive load_valid=1, load_mat=x and load_data=axi_in.data in the same cycle, and increment the beat counter.
REQ-026 When finish is seen in RD_x and the beat count, including that cycle, equals beats, the block SHALL advance to the next state.
REQ-027 When finish is seen with the count unequal to beats, the block SHALL pulse err and still advance.
REQ-028 rvalid outside the RD states SHALL be ignored, with load_valid=0.
REQ-029 On entry to COMPUTE, compute_start SHALL pulse exactly once; the block then waits for compute_done, which moves it to REQ_D.
REQ-030 WR_D SHALL wait for finish, then go to DONE; DONE SHALL pulse done for one cycle and return to IDLE.
REQ-031 start while busy SHALL be ignored; compute_done outside COMPUTE SHALL be ignored.

Reset
REQ-032 While rst is high, the block SHALL go to IDLE with every axi_out field 0 and load_valid, compute_start, busy, done, err all 0, beat counter and captured config cleared.
REQ-033 rst mid-transfer SHALL drop request_valid in the same cycle, and any outstanding beats SHALL be discarded.

Configuration
REQ-034 With TILE_FETCH_PERF_EN defined, output perf (SYSTOLIC_pkg_t) SHALL count cycles per tile:
  - systolic_time counts cycles spent in COMPUTE;
  - waitwrite_time counts cycles in REQ_D;
  - writeback_time counts cycles in WR_D;
  - all three clear on an accepted start and hold after DONE.
REQ-035 Without TILE_FETCH_PERF_EN, the perf port and its counters SHALL be absent.

Structure
REQ-036 The state enum (fetch_state_t) and the bytes-per-element and element-count constants SHALL live in the shared params package, next to shape_t, type_t, mat_t and the AXI types.
REQ-037 Beat computation SHALL be a combinational sub-module, tile_beat_calc, mapping (shape, datatype, mat) to burst_num.

Verification
REQ-038 M16K16N16 FP16 with zero-latency arready: burst_num is C=31, A=15, B=15, D=31; load_mat sequence is C, A, B; done pulses once.
REQ-039 M32K16N8 FP32: A burst_num=63; M8K16N32 INT4: B burst_num=7; no err.
REQ-040 arready held low 10 cycles in REQ_A: axi_out stays stable; REQ_A->RD_A on the first arready cycle.
REQ-041 finish after 14 of 16 B beats: err pulses once and the FSM proceeds to COMPUTE.
REQ-042 start with shape 2'b11: err pulses and busy stays 0; a second start during RD_C is ignored.
REQ-043 rst asserted in RD_A: outputs return to 0 and the next start replays the full sequence from REQ_C.
